// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - ID-stage hazard controller: load-use/external stall, EX redirect flush, counters
module hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter int MAX_STALL = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rt,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_redirect,
  input  logic             ext_stall,
  input  logic             cnt_clr,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic             stall_err
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    STALL    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  localparam int CW = $clog2(MAX_STALL + 2);
  localparam logic [CW-1:0] CONSEC_MAX  = CW'(MAX_STALL + 1);
  localparam logic [CW-1:0] CONSEC_LAST = CW'(MAX_STALL);

  state_t        cur_state;
  state_t        nxt_state;
  logic          lu;
  logic          stl;
  logic          stall_act;
  logic          redirect_act;
  logic [CW-1:0] consec;

  // r0 is never a real dependency, which also keeps a flushed NOP in ID from stalling
  assign lu  = ex_mem_read && (ex_rt != 5'd0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
  assign stl = lu || ext_stall;

  // Outputs are forced to run values while reset is asserted, independent of inputs
  assign redirect_act = rst_n && ex_redirect;
  assign stall_act    = rst_n && !ex_redirect && stl;

  always_comb begin
    nxt_state  = RUN;
    pc_write   = 1'b1;
    ifid_write = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    if (redirect_act) begin
      nxt_state  = REDIRECT;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (stall_act) begin
      nxt_state  = STALL;
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= RUN;
    end else begin
      cur_state <= nxt_state;
    end
  end

  assign state = cur_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      consec    <= '0;
      stall_err <= 1'b0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      consec    <= '0;
      stall_err <= 1'b0;
    end else begin
      if (stall_act && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + 1'b1;
      end
      if (redirect_act && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + 1'b1;
      end
      if (stall_act) begin
        if (consec != CONSEC_MAX) begin
          consec <= consec + 1'b1;
        end
        // This edge takes consec to MAX_STALL+1 (or it is already there)
        if (consec >= CONSEC_LAST) begin
          stall_err <= 1'b1;
        end
      end else begin
        consec <= '0;
      end
    end
  end

endmodule
